// File: rtl/cla_serial_adder.sv
// Serial WIDTH-bit adder: streams operands two bits per cycle through one
// 2-bit carry-lookahead slice, with valid/ready handshakes on both sides.

// 2-bit carry-lookahead slice with group generate/propagate outputs.
module cla_2 (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    input  logic       i_c,
    output logic [1:0] o_s,
    output logic       o_g,
    output logic       o_p
);
    logic [1:0] w_g;
    logic [1:0] w_p;
    logic       w_c1;

    assign w_g  = i_a & i_b;
    assign w_p  = i_a ^ i_b;
    assign w_c1 = w_g[0] | (w_p[0] & i_c);
    assign o_s  = {w_p[1] ^ w_c1, w_p[0] ^ i_c};
    assign o_g  = w_g[1] | (w_p[1] & w_g[0]);
    assign o_p  = w_p[1] & w_p[0];
endmodule

module cla_serial_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = ((WIDTH / 2) > 1) ? $clog2(WIDTH / 2) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);
    localparam int unsigned N  = WIDTH / 2;
    localparam int unsigned AW = (WIDTH > 2) ? WIDTH - 2 : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_in_ready_nxt;
    logic             w_out_valid_nxt;
    logic             w_busy_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_ovf;

    logic [1:0]       w_s;
    logic             w_g;
    logic             w_p;
    logic             w_c_nxt;
    logic             w_last;
    logic [AW-1:0]    w_acc_nxt;
    logic [WIDTH-1:0] w_sum_nxt;

    cla_2 u_slice (
        .i_a (r_a[1:0]),
        .i_b (r_b[1:0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_g (w_g),
        .o_p (w_p)
    );

    assign w_c_nxt = w_g | (w_p & r_carry);
    assign w_last  = (r_cnt == CW'(N - 1));

    // Partial sums enter from the top so slice 0 ends up at bit 0.
    generate
        if (WIDTH > 4) begin : g_acc_wide
            assign w_acc_nxt = {w_s, r_acc[AW-1:2]};
            assign w_sum_nxt = {w_s, r_acc};
        end else if (WIDTH == 4) begin : g_acc_4
            assign w_acc_nxt = w_s;
            assign w_sum_nxt = {w_s, r_acc};
        end else begin : g_acc_2
            assign w_acc_nxt = '0;
            assign w_sum_nxt = w_s;
        end
    endgenerate

    // State and handshake-flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state and next handshake flags.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt      = (w_state_nxt == S_RUN);
    end

    // Operand shifting, carry chaining and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 2;
                    r_b     <= r_b >> 2;
                    r_carry <= w_c_nxt;
                    r_acc   <= w_acc_nxt;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum   <= w_sum_nxt;
                        r_c_out <= w_c_nxt;
                        r_ovf   <= w_c_nxt ^ (r_a[1] ^ r_b[1] ^ w_s[1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed and random checks for cla_serial_adder at WIDTH=32.
module tb_cla_serial_adder;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    cla_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for IDLE, present operands for one accept edge; returns at the negedge after it.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ic);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        a        = ia;
        b        = ib;
        c_in     = ic;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for the result, hold it for stall cycles, then complete the handshake.
    task automatic collect(input int stall, output logic [31:0] rs, output logic rc,
                           output logic ro);
        int lat;
        logic [31:0] held;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("in_ready_after_accept", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd16);
        held      = sum;
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_sum_stable", 64'(sum), 64'(held));
        end
        rs        = sum;
        rc        = c_out;
        ro        = ovf;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_return", 64'(in_ready), 64'd1);
    endtask

    logic [31:0] rs;
    logic        rc;
    logic        ro;
    logic [31:0] ra, rb;
    logic        rci;
    logic [32:0] ref_full;
    logic        ref_ovf;
    int          vcount;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_c_out", 64'(c_out), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'h0000_0003, 32'h0000_0005, 1'b0);
        collect(0, rs, rc, ro);
        check("t1_sum", 64'(rs), 64'h0000_0008);
        check("t1_cout", 64'(rc), 64'd0);
        check("t1_ovf", 64'(ro), 64'd0);

        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        collect(1, rs, rc, ro);
        check("t2_sum", 64'(rs), 64'h0000_0000);
        check("t2_cout", 64'(rc), 64'd1);
        check("t2_ovf", 64'(ro), 64'd0);

        issue(32'h8000_0000, 32'h8000_0000, 1'b0);
        collect(0, rs, rc, ro);
        check("t3_sum", 64'(rs), 64'h0000_0000);
        check("t3_cout", 64'(rc), 64'd1);
        check("t3_ovf", 64'(ro), 64'd1);

        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        collect(2, rs, rc, ro);
        check("t4_sum", 64'(rs), 64'h8000_0000);
        check("t4_cout", 64'(rc), 64'd0);
        check("t4_ovf", 64'(ro), 64'd1);
        check("idle_sum_held", 64'(sum), 64'h8000_0000);
        check("idle_ovf_held", 64'(ovf), 64'd1);

        // Reset after slice 7 of a carry-heavy add.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_sum", 64'(sum), 64'd0);
        check("mrst_in_ready", 64'(in_ready), 64'd1);
        check("mrst_ovf", 64'(ovf), 64'd0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("mrst_no_stale_valid", 64'(vcount), 64'd0);
        issue(32'h1234_5678, 32'h1111_1111, 1'b0);
        collect(0, rs, rc, ro);
        check("mrst_sum_after", 64'(rs), 64'h2345_6789);
        check("mrst_cout_after", 64'(rc), 64'd0);

        // Backpressure with a competing request held during DONE.
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0);
        vcount = 0;
        while (!out_valid && vcount < 100) begin
            @(negedge clk);
            vcount++;
        end
        check("bp_latency", 64'(vcount), 64'd16);
        a         = 32'h0000_0010;
        b         = 32'h0000_0020;
        c_in      = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_sum", 64'(sum), 64'h0000_0100);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_in_ready", 64'(in_ready), 64'd1);
        check("bp_idle_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        collect(0, rs, rc, ro);
        check("bp_new_sum", 64'(rs), 64'h0000_0031);

        // Random transactions with random consumer stalls.
        for (int t = 0; t < 1000; t++) begin
            ra       = $urandom;
            rb       = $urandom;
            rci      = 1'($urandom_range(0, 1));
            ref_full = 33'(ra) + 33'(rb) + 33'(rci);
            ref_ovf  = (ra[31] == rb[31]) && (ref_full[31] != ra[31]);
            issue(ra, rb, rci);
            collect(int'($urandom_range(0, 3)), rs, rc, ro);
            check("rnd_sum", 64'(rs), 64'(ref_full[31:0]));
            check("rnd_cout", 64'(rc), 64'(ref_full[32]));
            check("rnd_ovf", 64'(ro), 64'(ref_ovf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
